// File: rtl/k_dp_2deep_fifo_ctrl.sv
// Control stage for the 2-entry dual-port FIFO RAM: pointers, status, one-op-per-cycle
// write/read arbitration and pop-data valid strobe.
module k_dp_2deep_fifo_ctrl #(
    parameter int data_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    input  logic [data_size-1:0] wr_data,
    output logic                 wr_ready,
    input  logic                 rd_req,
    output logic                 rd_gnt,
    output logic                 rd_dvalid,
    output logic [data_size-1:0] rd_data,
    output logic [1:0]           count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 ram_wen,
    output logic                 ram_waddr,
    output logic                 ram_raddr,
    output logic [data_size-1:0] ram_d,
    input  logic [data_size-1:0] ram_q
);

    typedef enum logic {
        PRI_WR = 1'b0,
        PRI_RD = 1'b1
    } arb_state_e;

    arb_state_e state_q;
    arb_state_e state_d;

    logic [1:0] wptr_q;
    logic [1:0] wptr_d;
    logic [1:0] rptr_q;
    logic [1:0] rptr_d;
    logic       rd_dvalid_q;
    logic       overflow_q;
    logic       overflow_d;
    logic       underflow_q;
    logic       underflow_d;

    logic [1:0] count_s;
    logic       full_s;
    logic       empty_s;
    logic       w_ok_s;
    logic       r_ok_s;
    logic       wr_ready_s;
    logic       wr_grant_s;
    logic       rd_grant_s;

    // Occupancy from the wrap-bit pointers and the legal-request qualifiers
    always_comb begin
        count_s = wptr_q - rptr_q;
        full_s  = (count_s == 2'd2);
        empty_s = (count_s == 2'd0);
        w_ok_s  = wr_valid & ~full_s;
        r_ok_s  = rd_req & ~empty_s;
    end

    // Arbitration: the state only matters when both sides are legal
    always_comb begin
        wr_ready_s = 1'b0;
        rd_grant_s = 1'b0;
        case (state_q)
            PRI_WR: begin
                wr_ready_s = ~full_s;
                rd_grant_s = r_ok_s & ~w_ok_s;
            end
            PRI_RD: begin
                wr_ready_s = ~full_s & ~r_ok_s;
                rd_grant_s = r_ok_s;
            end
            default: begin
                wr_ready_s = 1'b0;
                rd_grant_s = 1'b0;
            end
        endcase
        wr_grant_s = wr_valid & wr_ready_s;
    end

    // Next-state for pointers, priority state and sticky error flags
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        state_d     = state_q;
        overflow_d  = overflow_q | (wr_valid & full_s);
        underflow_d = underflow_q | (rd_req & empty_s);

        if (wr_grant_s) begin
            wptr_d = wptr_q + 2'd1;
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_grant_s) begin
            rptr_d = rptr_q + 2'd1;
        end else begin
            rptr_d = rptr_q;
        end

        // Priority flips only on a genuine conflict
        if (w_ok_s & r_ok_s) begin
            case (state_q)
                PRI_WR:  state_d = PRI_RD;
                PRI_RD:  state_d = PRI_WR;
                default: state_d = PRI_WR;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers; async reset also squashes a pending rd_dvalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= 2'd0;
            rptr_q      <= 2'd0;
            state_q     <= PRI_WR;
            rd_dvalid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            state_q     <= state_d;
            rd_dvalid_q <= rd_grant_s;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Output mapping; RAM address is the low pointer bit
    always_comb begin
        wr_ready  = wr_ready_s;
        rd_gnt    = rd_grant_s;
        rd_dvalid = rd_dvalid_q;
        rd_data   = ram_q;
        count     = count_s;
        full      = full_s;
        empty     = empty_s;
        overflow  = overflow_q;
        underflow = underflow_q;
        ram_wen   = wr_grant_s;
        ram_waddr = wptr_q[0];
        ram_raddr = rptr_q[0];
        ram_d     = wr_data;
    end

endmodule

// File: tb/tb_k_dp_2deep_fifo_ctrl.sv
// Directed bench for k_dp_2deep_fifo_ctrl with a behavioural 2-entry RAM
// (q loads mem[raddr] on every non-write edge).
module tb_k_dp_2deep_fifo_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic          rd_gnt;
    logic          rd_dvalid;
    logic [DW-1:0] rd_data;
    logic [1:0]    count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;
    logic          ram_wen;
    logic          ram_waddr;
    logic          ram_raddr;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] mem [0:1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    k_dp_2deep_fifo_ctrl #(.data_size(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_req    (rd_req),
        .rd_gnt    (rd_gnt),
        .rd_dvalid (rd_dvalid),
        .rd_data   (rd_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow),
        .ram_wen   (ram_wen),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_d     (ram_d),
        .ram_q     (ram_q)
    );

    // Behavioural RAM
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_d;
        else         ram_q <= mem[ram_raddr];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_count"}, 32'(count), 32'd0);
        check_val({tag, "_empty"}, 32'(empty), 32'd1);
        check_val({tag, "_full"}, 32'(full), 32'd0);
        check_val({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        check_val({tag, "_rd_dvalid"}, 32'(rd_dvalid), 32'd0);
        check_val({tag, "_overflow"}, 32'(overflow), 32'd0);
        check_val({tag, "_underflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_w;
        logic [3:0] exp_r;

        mem[0]   = 8'h00;
        mem[1]   = 8'h00;
        ram_q    = 8'h00;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        rd_req   = 1'b0;
        #1;
        check_reset_state("por");
        step();
        step();
        rst = 1'b0;

        // Two pushes to full
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        settle();
        check_val("push1_wen", 32'(ram_wen), 32'd1);
        check_val("push1_waddr", 32'(ram_waddr), 32'd0);
        check_val("push1_d", 32'(ram_d), 32'hA5);
        step();
        check_val("push1_count", 32'(count), 32'd1);
        wr_data = 8'h3C;
        settle();
        check_val("push2_waddr", 32'(ram_waddr), 32'd1);
        check_val("push2_wen", 32'(ram_wen), 32'd1);
        step();
        wr_valid = 1'b0;
        settle();
        check_val("full_count", 32'(count), 32'd2);
        check_val("full_flag", 32'(full), 32'd1);
        check_val("full_wr_ready", 32'(wr_ready), 32'd0);

        // rd_req held three cycles from full: two grants, then empty
        rd_req = 1'b1;
        settle();
        check_val("pop1_gnt", 32'(rd_gnt), 32'd1);
        check_val("pop1_raddr", 32'(ram_raddr), 32'd0);
        step();
        check_val("pop1_dvalid", 32'(rd_dvalid), 32'd1);
        check_val("pop1_data", 32'(rd_data), 32'hA5);
        check_val("pop2_gnt", 32'(rd_gnt), 32'd1);
        check_val("pop2_raddr", 32'(ram_raddr), 32'd1);
        step();
        check_val("pop2_dvalid", 32'(rd_dvalid), 32'd1);
        check_val("pop2_data", 32'(rd_data), 32'h3C);
        check_val("pop3_empty", 32'(empty), 32'd1);
        check_val("pop3_no_gnt", 32'(rd_gnt), 32'd0);
        step();
        rd_req = 1'b0;
        settle();
        check_val("pop3_no_dvalid", 32'(rd_dvalid), 32'd0);
        check_val("pop3_underflow", 32'(underflow), 32'd1);

        // Six words interleaved; pointers start at 2 so they wrap past 3
        for (int i = 1; i <= 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            rd_req   = 1'b0;
            settle();
            check_val($sformatf("il%0d_waddr", i), 32'(ram_waddr), 32'((i - 1) & 1));
            if (i > 1) begin
                check_val($sformatf("il%0d_dvalid", i - 1), 32'(rd_dvalid), 32'd1);
                check_val($sformatf("il%0d_data", i - 1), 32'(rd_data), 32'(i - 1));
            end
            step();
            wr_valid = 1'b0;
            rd_req   = 1'b1;
            settle();
            check_val($sformatf("il%0d_gnt", i), 32'(rd_gnt), 32'd1);
            step();
            rd_req = 1'b0;
        end
        settle();
        check_val("il6_dvalid", 32'(rd_dvalid), 32'd1);
        check_val("il6_data", 32'(rd_data), 32'h06);
        check_val("il_underflow_sticky", 32'(underflow), 32'd1);

        // Asynchronous reset mid-cycle squashes the live rd_dvalid
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        step();
        rst = 1'b0;

        // count=1 then both held: forced grants at full/empty don't flip priority
        wr_valid = 1'b1;
        wr_data  = 8'h11;
        step();
        wr_data = 8'h22;
        rd_req  = 1'b1;
        exp_w   = 4'b1001;
        exp_r   = 4'b0110;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) wr_data = 8'h33;
            settle();
            check_val($sformatf("arb%0d_wen", c), 32'(ram_wen), 32'(exp_w[c]));
            check_val($sformatf("arb%0d_gnt", c), 32'(rd_gnt), 32'(exp_r[c]));
            check_val($sformatf("arb%0d_excl", c), 32'(ram_wen & rd_gnt), 32'd0);
            if (c == 2) check_val("arb_data1", 32'(rd_data), 32'h11);
            if (c == 3) check_val("arb_data2", 32'(rd_data), 32'h22);
            step();
        end
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        settle();
        check_val("arb_count", 32'(count), 32'd1);

        rst = 1'b1;
        settle();
        rst = 1'b0;

        // Overflow / underflow are sticky and leave the pointers alone
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        step();
        wr_data = 8'hC3;
        step();
        wr_data = 8'hEE;
        settle();
        check_val("ovf_wr_ready", 32'(wr_ready), 32'd0);
        check_val("ovf_wen", 32'(ram_wen), 32'd0);
        step();
        wr_valid = 1'b0;
        settle();
        check_val("ovf_flag", 32'(overflow), 32'd1);
        check_val("ovf_count", 32'(count), 32'd2);
        rd_req = 1'b1;
        step();
        check_val("ovf_data1", 32'(rd_data), 32'h5A);
        step();
        settle();
        check_val("ovf_data2", 32'(rd_data), 32'hC3);
        check_val("unf_no_gnt", 32'(rd_gnt), 32'd0);
        step();
        rd_req = 1'b0;
        settle();
        check_val("unf_flag", 32'(underflow), 32'd1);
        check_val("unf_count", 32'(count), 32'd0);
        step();
        step();
        step();
        check_val("ovf_hold", 32'(overflow), 32'd1);
        check_val("unf_hold", 32'(underflow), 32'd1);

        // Reset asserted during a rd_gnt cycle: no rd_dvalid afterwards
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        step();
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        settle();
        check_val("rstgnt_gnt", 32'(rd_gnt), 32'd1);
        #1;
        rst = 1'b1;
        step();
        rd_req = 1'b0;
        check_reset_state("rstgnt");
        rst = 1'b0;
        step();
        check_val("rstgnt_dvalid_after", 32'(rd_dvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
